// File: rtl/clm_remask_sched_pkg.sv
// Shared types for the re-mask scheduler slice.
// state_t     : masked round state
// red_poly_t  : one word of PRNG randomness (reduced polynomial)
// mr_matrix_t : matrix P, one state_t row per randomness bit
// remask_fsm_t: scheduler FSM states
package clm_remask_sched_pkg;

  localparam int unsigned CLM_D   = 2;
  localparam int unsigned RED_W   = 8;
  localparam int unsigned STATE_W = 16;

  typedef logic [STATE_W-1:0]              state_t;
  typedef logic [RED_W-1:0]                red_poly_t;
  typedef logic [RED_W-1:0][STATE_W-1:0]   mr_matrix_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RND = 2'd1,
    OUT_HOLD = 2'd2
  } remask_fsm_t;

endpackage

// File: rtl/clm_rr_arb.sv
// Combinational round-robin picker. Search starts one past ptr and wraps.
// Ports:
//   req : request vector
//   ptr : index of the last served requester
//   gnt : one-hot grant (all zero when no request)
//   idx : index of the granted requester
module clm_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      j = IW'((int'(ptr) + k) % int'(NUM_REQ));
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/mul_add_p.sv
// Computes y = x XOR (r times P) over GF(2), processed share by share.
// Ports:
//   x : state to mask
//   r : randomness word
//   m : matrix P, row i is added when r[i] is set
//   y : masked state (combinational)
module mul_add_p
  import clm_remask_sched_pkg::*;
#(
  parameter int unsigned d = CLM_D
) (
  input  state_t     x,
  input  red_poly_t  r,
  input  mr_matrix_t m,
  output state_t     y
);

  localparam int unsigned ShareW = STATE_W / d;

  always_comb begin
    y = x;
    for (int s = 0; s < int'(d); s++) begin
      for (int i = 0; i < int'(RED_W); i++) begin
        if (r[i]) begin
          y[s*ShareW +: ShareW] = y[s*ShareW +: ShareW] ^ m[i][s*ShareW +: ShareW];
        end
      end
    end
  end

endmodule

// File: rtl/clm_remask_sched.sv
// Time-shares one mul_add_p between NUM_REQ requesters. A granted state is
// masked with one PRNG word and presented downstream with the requester ID.
// Ports:
//   clk, rst               : clock, async active-high reset
//   M                      : matrix P, stable while busy
//   req_valid/state/ready  : requester side, req_ready is a Mealy one-hot grant
//   rnd_valid/data/ready   : PRNG handshake, ready only while waiting for a word
//   out_valid/state/id/ready : downstream result, held until accepted
//   busy                   : FSM not idle
//   remask_cnt             : saturating count of completed jobs
//   rnd_starve             : sticky flag, randomness wait reached TIMEOUT
module clm_remask_sched
  import clm_remask_sched_pkg::*;
#(
  parameter int unsigned d       = CLM_D,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned IW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  mr_matrix_t                 M,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  state_t [NUM_REQ-1:0]       req_state,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       rnd_valid,
  input  red_poly_t                  rnd_data,
  output logic                       rnd_ready,
  output logic                       out_valid,
  output state_t                     out_state,
  output logic [IW-1:0]              out_id,
  input  logic                       out_ready,
  output logic                       busy,
  output logic [CNT_W-1:0]           remask_cnt,
  output logic                       rnd_starve
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  remask_fsm_t         fsm_q;
  state_t              hold_q;
  logic [IW-1:0]       id_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [WaitW-1:0]    wait_q;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       gnt_idx;
  state_t              masked;

  clm_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  mul_add_p #(
    .d (d)
  ) u_mul_add (
    .x (hold_q),
    .r (rnd_data),
    .m (M),
    .y (masked)
  );

  // Gating with rst drops the grant as soon as reset asserts, not at the next edge.
  assign req_ready = (fsm_q == IDLE && !rst) ? gnt : '0;
  assign rnd_ready = (fsm_q == WAIT_RND);
  assign busy      = (fsm_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= IDLE;
      hold_q     <= '0;
      id_q       <= '0;
      rr_ptr_q   <= IW'(NUM_REQ - 1);
      wait_q     <= '0;
      out_valid  <= 1'b0;
      out_state  <= '0;
      out_id     <= '0;
      remask_cnt <= '0;
      rnd_starve <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (|gnt) begin
            hold_q   <= req_state[gnt_idx];
            id_q     <= gnt_idx;
            rr_ptr_q <= gnt_idx;
            wait_q   <= '0;
            fsm_q    <= WAIT_RND;
          end
        end
        WAIT_RND: begin
          if (rnd_valid) begin
            out_state <= masked;
            out_id    <= id_q;
            out_valid <= 1'b1;
            if (remask_cnt != '1) begin
              remask_cnt <= remask_cnt + 1'b1;
            end
            fsm_q <= OUT_HOLD;
          end else begin
            // Counter parks at TIMEOUT; the flag latches on the edge it gets there.
            if (wait_q != WaitW'(TIMEOUT)) begin
              wait_q <= wait_q + 1'b1;
            end
            if (wait_q == WaitW'(TIMEOUT - 1)) begin
              rnd_starve <= 1'b1;
            end
          end
        end
        OUT_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm_q     <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/clm_remask_sched.md
Name: clm_remask_sched

Overview:
- Time-shares one mul_add_p instance (mul_P plus XOR) between NUM_REQ requesters that need a state re-masked with a fresh random codeword.
- Arbitrates round-robin and pulls one red_poly_t of randomness per job from the PRNG over a valid/ready handshake.
- Delivers the registered masked state and the requester ID downstream.
- Sits between the round datapath lanes and the shared PRNG.

Parameters:
- d, d: codebase code parameter, passed unchanged to mul_add_p.
- NUM_REQ, 4: number of requesters; legal range 2..16.
- CNT_W, 16: width of the completed-job counter.
- TIMEOUT, 64: wait-for-randomness cycles before rnd_starve sets; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- M  in  mr_matrix_t  matrix for mul_P; held stable while busy=1.
- req_valid  in  NUM_REQ  per-requester request.
- req_state  in  NUM_REQ x state_t  per-requester state to mask.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- rnd_valid  in  1  PRNG word available.
- rnd_data  in  red_poly_t  randomness r.
- rnd_ready  out  1  consume rnd_data.
- out_valid  out  1  masked result valid.
- out_state  out  state_t  equals captured state XOR (r times P).
- out_id  out  max(1,$clog2(NUM_REQ))  index of the served requester.
- out_ready  in  1  downstream accept.
- busy  out  1  FSM not in IDLE.
- remask_cnt  out  CNT_W  completed jobs; saturating.
- rnd_starve  out  1  sticky randomness-timeout flag.

Behaviour:
- Reset values: FSM=IDLE; all req_ready, rnd_ready, out_valid=0; out_state=0; out_id=0; remask_cnt=0; rnd_starve=0; rr_ptr=NUM_REQ-1, so requester 0 has first priority; wait counter=0.
- FSM states: IDLE, WAIT_RND, OUT_HOLD.
- IDLE:
  - Grant search starts at (rr_ptr+1) mod NUM_REQ and wraps upward.
  - The first requester with req_valid=1 gets req_ready=1 combinationally in the same cycle. req_ready is Mealy and at most one bit is set.
  - On that edge: latch req_state into hold_reg and the index into id_reg, set rr_ptr=index, clear the wait counter, go to WAIT_RND.
  - With no req_valid, stay in IDLE with all req_ready=0.
- WAIT_RND:
  - rnd_ready=1.
  - If rnd_valid=1: out_state <= hold_reg XOR mul_P(rnd_data, M) through the single mul_add_p instance. Also out_id <= id_reg, out_valid <= 1, remask_cnt increments (holds at all-ones), go to OUT_HOLD.
  - Otherwise the wait counter increments. When it reaches TIMEOUT, rnd_starve <= 1. The flag is sticky until rst. The FSM keeps waiting and never aborts.
- OUT_HOLD:
  - out_valid=1. out_state and out_id are held stable.
  - On out_valid and out_ready, go to IDLE and clear out_valid on that edge.
  - No new grant in OUT_HOLD.
  - out_state keeps its last value after out_valid drops; it is don't-care.
- Latency and throughput:
  - Grant to out_valid is 1 cycle plus the number of rnd_valid stall cycles; minimum 2 edges.
  - One job per 3 cycles maximum.
- Each rnd_data word is consumed exactly once, in WAIT_RND only; it is never reused across jobs.
- Simultaneous events:
  - Requesters that are not granted see req_ready=0 and must hold req_valid and req_state.
  - req_valid dropping in the grant cycle is illegal.
- Reset mid-operation (any state) discards the job immediately. Outputs go to reset values asynchronously. The PRNG word is not consumed unless rnd_ready was sampled high on an edge before rst.
- Widths: all XOR is bitwise over state_t. rr_ptr and id_reg use out_id width. remask_cnt saturates and does not wrap.

Decomposition:
- state_t, red_poly_t and mr_matrix_t come from the existing types package (clm_typedefs.svh).
- Add to that package: the remask_fsm_t enum (IDLE, WAIT_RND, OUT_HOLD).
- Sub-module: the existing mul_add_p, instantiated once.
- The round-robin picker is natural as a small combinational sub-module, clm_rr_arb: inputs req vector and ptr; outputs one-hot grant and index.

Test Plan:
- Single job, zero mask: req0 with state=S, rnd_data=0 → out_state==S, out_id=0, remask_cnt=1, 2 edges after grant.
- Nonzero mask: random r and M, 100 jobs with rnd_valid always 1 → out_state matches a golden S XOR mul_P(r,M) model every time; remask_cnt=100.
- Arbitration: req_valid=4'b1011 held continuously → grant order 0,1,3,0,1,3; never two req_ready bits high together.
- Backpressure: out_ready=0 for 5 cycles → out_valid, out_state and out_id are stable; no req_ready and no rnd_ready asserted; completion on the first out_ready=1.
- Starvation: rnd_valid=0 for TIMEOUT+2 cycles in WAIT_RND → rnd_starve=1 exactly at count TIMEOUT. rnd_valid=1 then completes the job, and rnd_starve stays 1.
- Reset mid-op: assert rst while in WAIT_RND → busy, out_valid, rnd_ready and req_ready drop asynchronously. After release, req0 is served first, with no stale output.
